// File: rtl/bpb_update_ctrl.sv
// bpb_update_ctrl: sequences the BHT two-phase update (arm, then commit).
// EX branch resolutions queue in a small FIFO. Each drain borrows the BHT
// index port, which IF lookups normally own. A starvation counter forces an
// arm once lookups have blocked it for STARVE_LIMIT consecutive cycles.
// Optional feature macro: BPB_FLUSH_EN adds flush_i, which discards queued
// entries and any arm in progress.
// INDEX_WIDTH defaults to 6.

module bpb_update_ctrl #(
  parameter int INDEX_WIDTH  = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   lookup_req_i,
  input  logic [INDEX_WIDTH-1:0] lookup_index_i,
  output logic                   lookup_stall_o,
  input  logic                   resolve_valid_i,
  output logic                   resolve_ready_o,
  input  logic [INDEX_WIDTH-1:0] resolve_index_i,
  input  logic                   resolve_taken_i,
`ifdef BPB_FLUSH_EN
  input  logic                   flush_i,
`endif
  output logic                   tbl_en_o,
  output logic                   tbl_update_en_o,
  output logic                   tbl_last_taken_o,
  output logic [INDEX_WIDTH-1:0] tbl_index_o,
  output logic                   busy_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {IDLE = 1'b0, COMMIT = 1'b1} state_t;

  state_t state_reg, state_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;

  // Small register-file FIFO. The head must be visible in the same cycle,
  // so this storage is read asynchronously.
  logic [INDEX_WIDTH-1:0] idx_mem [FIFO_DEPTH];
  logic                   tkn_mem [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic flush;
  logic [INDEX_WIDTH-1:0] head_index;
  logic                   head_taken;

`ifdef BPB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign fifo_empty      = (count_reg == '0);
  assign fifo_full       = (count_reg == FULL_COUNT);
  assign resolve_ready_o = !fifo_full;
  // A push during a flush is dropped.
  assign push            = resolve_valid_i && !fifo_full && !flush;
  assign head_index      = idx_mem[rd_ptr_reg];
  assign head_taken      = tkn_mem[rd_ptr_reg];
  assign busy_o          = !fifo_empty || (state_reg == COMMIT);

  // FIFO storage write; contents need no reset because count gates their use.
  always_ff @(posedge clk_i) begin
    if (push) begin
      idx_mem[wr_ptr_reg] <= resolve_index_i;
      tkn_mem[wr_ptr_reg] <= resolve_taken_i;
    end
  end

  // State, pointer, count and starvation registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Arbitration between lookups and updates, table drive and next state.
  always_comb begin
    state_next       = state_reg;
    starve_cnt_next  = starve_cnt_reg;
    tbl_en_o         = 1'b0;
    tbl_update_en_o  = 1'b0;
    tbl_last_taken_o = 1'b0;
    tbl_index_o      = lookup_index_i;
    lookup_stall_o   = 1'b0;
    pop              = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fifo_empty) begin
          starve_cnt_next = '0;
        end else if (!lookup_req_i) begin
          tbl_en_o        = 1'b1;
          tbl_index_o     = head_index;
          state_next      = COMMIT;
          starve_cnt_next = '0;
        end else if (starve_cnt_reg < STARVE_MAX) begin
          starve_cnt_next = starve_cnt_reg + 1'b1;
        end else begin
          tbl_en_o        = 1'b1;
          tbl_index_o     = head_index;
          lookup_stall_o  = 1'b1;
          state_next      = COMMIT;
          starve_cnt_next = '0;
        end
      end
      COMMIT: begin
        // The lookup keeps the port. It reads the pre-write entry value.
        tbl_en_o         = 1'b1;
        tbl_update_en_o  = 1'b1;
        tbl_last_taken_o = head_taken;
        tbl_index_o      = lookup_req_i ? lookup_index_i : head_index;
        pop              = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      // Any commit in this cycle still writes. An arm in this cycle is abandoned.
      state_next      = IDLE;
      starve_cnt_next = '0;
    end
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end
  end

endmodule

// File: tb/tb_bpb_update_ctrl.sv
// Directed self-checking bench for bpb_update_ctrl.
// The bench drives inputs 1 ns after each rising edge.
// It checks the combinational outputs 1 ns later.
// Build with BPB_FLUSH_EN defined to add the flush scenario.

module tb_bpb_update_ctrl;

  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          lookup_req;
  logic [IW-1:0] lookup_index;
  logic          lookup_stall;
  logic          resolve_valid;
  logic          resolve_ready;
  logic [IW-1:0] resolve_index;
  logic          resolve_taken;
  logic          tbl_en;
  logic          tbl_update_en;
  logic          tbl_last_taken;
  logic [IW-1:0] tbl_index;
  logic          busy;
`ifdef BPB_FLUSH_EN
  logic          flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bpb_update_ctrl #(
    .INDEX_WIDTH (IW),
    .FIFO_DEPTH  (4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .lookup_req_i    (lookup_req),
    .lookup_index_i  (lookup_index),
    .lookup_stall_o  (lookup_stall),
    .resolve_valid_i (resolve_valid),
    .resolve_ready_o (resolve_ready),
    .resolve_index_i (resolve_index),
    .resolve_taken_i (resolve_taken),
`ifdef BPB_FLUSH_EN
    .flush_i         (flush),
`endif
    .tbl_en_o        (tbl_en),
    .tbl_update_en_o (tbl_update_en),
    .tbl_last_taken_o(tbl_last_taken),
    .tbl_index_o     (tbl_index),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  // Move to 1 ns after the next rising edge. Inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let the combinational outputs settle after the inputs change.
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lookup_req = 1'b0;
    lookup_index = 6'd9;
    resolve_valid = 1'b0;
    resolve_index = '0;
    resolve_taken = 1'b0;
`ifdef BPB_FLUSH_EN
    flush = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lookup_req = 1'b0;
    lookup_index = 6'd9;
    resolve_valid = 1'b0;
    resolve_index = '0;
    resolve_taken = 1'b0;
`ifdef BPB_FLUSH_EN
    flush = 1'b0;
`endif
    tick();
    n_checks++;
    if ({tbl_en, tbl_update_en, lookup_stall, busy, resolve_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_outputs: en/upd/stall/busy/ready=%b required 00001",
               {tbl_en, tbl_update_en, lookup_stall, busy, resolve_ready});
    end
    n_checks++;
    if (tbl_index !== 6'd9) begin
      n_fail++;
      $display("FAIL reset_index: got %0d required 9", tbl_index);
    end
    rst = 1'b0;
    tick();
    $display("reset: en=%b upd=%b ready=%b busy=%b", tbl_en, tbl_update_en, resolve_ready, busy);
  endtask

  task automatic test_single();
    do_reset();
    resolve_valid = 1'b1;
    resolve_index = 6'd5;
    resolve_taken = 1'b1;
    settle();
    n_checks++;
    if (tbl_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_bypass: en=%b required 0", tbl_en);
    end
    tick();
    resolve_valid = 1'b0;
    settle();
    n_checks++;
    if ({tbl_en, tbl_update_en, tbl_index, busy} !== {1'b1, 1'b0, 6'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL single_arm: en=%b upd=%b idx=%0d busy=%b required 1 0 5 1",
               tbl_en, tbl_update_en, tbl_index, busy);
    end
    tick();
    n_checks++;
    if ({tbl_en, tbl_update_en, tbl_last_taken, tbl_index} !== {1'b1, 1'b1, 1'b1, 6'd5}) begin
      n_fail++;
      $display("FAIL single_commit: en=%b upd=%b tk=%b idx=%0d required 1 1 1 5",
               tbl_en, tbl_update_en, tbl_last_taken, tbl_index);
    end
    tick();
    n_checks++;
    if ({busy, tbl_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b en=%b required 0 0", busy, tbl_en);
    end
    $display("single: push idx5 taken1 committed");
  endtask

  task automatic test_full();
    logic [IW-1:0] exp_idx [4];
    logic          exp_tk  [4];
    exp_idx[0] = 6'd1; exp_idx[1] = 6'd2; exp_idx[2] = 6'd3; exp_idx[3] = 6'd4;
    exp_tk[0]  = 1'b1; exp_tk[1]  = 1'b0; exp_tk[2]  = 1'b1; exp_tk[3]  = 1'b1;
    do_reset();
    lookup_req = 1'b1;
    lookup_index = 6'd20;
    for (int i = 0; i < 4; i++) begin
      resolve_valid = 1'b1;
      resolve_index = exp_idx[i];
      resolve_taken = exp_tk[i];
      tick();
    end
    resolve_index = 6'd9;
    resolve_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++;
      if ({resolve_ready, tbl_en} !== 2'b00) begin
        n_fail++;
        $display("FAIL full_ready_%0d: ready=%b en=%b required 0 0", i, resolve_ready, tbl_en);
      end
      tick();
    end
    resolve_valid = 1'b0;
    lookup_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_checks++;
      if ({tbl_en, tbl_update_en, tbl_index} !== {1'b1, 1'b0, exp_idx[i]}) begin
        n_fail++;
        $display("FAIL full_arm_%0d: en=%b upd=%b idx=%0d required 1 0 %0d",
                 i, tbl_en, tbl_update_en, tbl_index, exp_idx[i]);
      end
      tick();
      n_checks++;
      if ({tbl_update_en, tbl_index, tbl_last_taken} !== {1'b1, exp_idx[i], exp_tk[i]}) begin
        n_fail++;
        $display("FAIL full_commit_%0d: upd=%b idx=%0d tk=%b required 1 %0d %b",
                 i, tbl_update_en, tbl_index, tbl_last_taken, exp_idx[i], exp_tk[i]);
      end
      tick();
    end
    n_checks++;
    if ({busy, tbl_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_drained: busy=%b en=%b required 0 0", busy, tbl_en);
    end
    $display("full: 4 entries queued, 5th refused, drained in order");
  endtask

  task automatic test_starve();
    do_reset();
    lookup_req = 1'b1;
    lookup_index = 6'd2;
    resolve_valid = 1'b1;
    resolve_index = 6'd11;
    resolve_taken = 1'b0;
    tick();
    resolve_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      n_checks++;
      if ({tbl_en, lookup_stall, tbl_index} !== {1'b0, 1'b0, 6'd2}) begin
        n_fail++;
        $display("FAIL starve_lookup_%0d: en=%b stall=%b idx=%0d required 0 0 2",
                 i, tbl_en, lookup_stall, tbl_index);
      end
      tick();
    end
    settle();
    n_checks++;
    if ({tbl_en, tbl_update_en, lookup_stall, tbl_index} !== {1'b1, 1'b0, 1'b1, 6'd11}) begin
      n_fail++;
      $display("FAIL starve_forced_arm: en=%b upd=%b stall=%b idx=%0d required 1 0 1 11",
               tbl_en, tbl_update_en, lookup_stall, tbl_index);
    end
    tick();
    n_checks++;
    if ({tbl_en, tbl_update_en, lookup_stall, tbl_index, tbl_last_taken} !==
        {1'b1, 1'b1, 1'b0, 6'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL starve_commit: en=%b upd=%b stall=%b idx=%0d tk=%b required 1 1 0 2 0",
               tbl_en, tbl_update_en, lookup_stall, tbl_index, tbl_last_taken);
    end
    tick();
    lookup_req = 1'b0;
    settle();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_idle: busy=%b required 0", busy);
    end
    $display("starve: 8 lookups served, forced arm, commit alongside lookup");
  endtask

  task automatic test_lookup_in_commit();
    do_reset();
    resolve_valid = 1'b1;
    resolve_index = 6'd7;
    resolve_taken = 1'b1;
    tick();
    resolve_valid = 1'b0;
    tick();
    lookup_req = 1'b1;
    lookup_index = 6'd3;
    settle();
    n_checks++;
    if ({tbl_index, tbl_update_en, lookup_stall, tbl_last_taken} !== {6'd3, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL lookup_in_commit: idx=%0d upd=%b stall=%b tk=%b required 3 1 0 1",
               tbl_index, tbl_update_en, lookup_stall, tbl_last_taken);
    end
    tick();
    lookup_req = 1'b0;
    $display("lookup_in_commit: lookup idx3 during commit of idx7");
  endtask

  task automatic test_back_to_back();
    do_reset();
    resolve_valid = 1'b1;
    resolve_index = 6'd12;
    resolve_taken = 1'b0;
    tick();
    resolve_index = 6'd13;
    resolve_taken = 1'b1;
    settle();
    n_checks++;
    if ({tbl_en, tbl_update_en, tbl_index} !== {1'b1, 1'b0, 6'd12}) begin
      n_fail++;
      $display("FAIL b2b_arm_a: en=%b upd=%b idx=%0d required 1 0 12", tbl_en, tbl_update_en, tbl_index);
    end
    tick();
    resolve_valid = 1'b0;
    settle();
    n_checks++;
    if ({tbl_update_en, tbl_index, tbl_last_taken} !== {1'b1, 6'd12, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_commit_a: upd=%b idx=%0d tk=%b required 1 12 0",
               tbl_update_en, tbl_index, tbl_last_taken);
    end
    tick();
    n_checks++;
    if ({tbl_en, tbl_update_en, tbl_index} !== {1'b1, 1'b0, 6'd13}) begin
      n_fail++;
      $display("FAIL b2b_arm_b: en=%b upd=%b idx=%0d required 1 0 13", tbl_en, tbl_update_en, tbl_index);
    end
    tick();
    n_checks++;
    if ({tbl_update_en, tbl_index, tbl_last_taken} !== {1'b1, 6'd13, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_commit_b: upd=%b idx=%0d tk=%b required 1 13 1",
               tbl_update_en, tbl_index, tbl_last_taken);
    end
    tick();
    $display("back_to_back: idx12 then idx13 retired in order");
  endtask

`ifdef BPB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    lookup_req = 1'b1;
    lookup_index = 6'd0;
    for (int i = 0; i < 3; i++) begin
      resolve_valid = 1'b1;
      resolve_index = 6'(30 + i);
      resolve_taken = 1'b1;
      tick();
    end
    resolve_valid = 1'b0;
    lookup_req = 1'b0;
    tick();
    flush = 1'b1;
    settle();
    n_checks++;
    if ({tbl_update_en, tbl_index} !== {1'b1, 6'd30}) begin
      n_fail++;
      $display("FAIL flush_commit: upd=%b idx=%0d required 1 30", tbl_update_en, tbl_index);
    end
    tick();
    flush = 1'b0;
    settle();
    n_checks++;
    if ({busy, tbl_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_after: busy=%b en=%b required 0 0", busy, tbl_en);
    end
    $display("flush: commit of idx30 completed, queue discarded");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_full();
    test_starve();
    test_lookup_in_commit();
    test_back_to_back();
`ifdef BPB_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
